// File: rtl/cnt_monitor.sv
// cnt_monitor: passive checker for an up-counter interface.
//
// Samples the monitored counter's enable and count value on every rising clock edge,
// predicts the value the counter must show at the following edge, and flags any step
// that breaks the counting rule:
//   clear -> 0, enabled -> +1 (mod 2^N), disabled -> hold.
// The enable sampled at one edge governs the count observed at the next edge.
//
// Parameters
//   N       counter width in bits (2..16)
//   ERR_W   width of the saturating error counter
//   RESYNC  consecutive correct steps needed to regain lock (1..15)
//
// Ports
//   clk      in   rising-edge clock shared with the monitored counter
//   clr_n    in   synchronous active-low clear, same signal that clears the counter
//   ena      in   enable seen by the monitored counter
//   cnt      in   count value of the monitored counter
//   exp_cnt  out  value expected at the next sampling edge
//   locked   out  high while tracking with no unresolved error
//   err      out  one-cycle pulse per detected error
//   wrap     out  one-cycle pulse on a correct max-to-0 step
//   err_cnt  out  number of detected errors, saturating at all-ones
//
// All outputs are registered.

module cnt_monitor #(
    parameter int unsigned N      = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned RESYNC = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ena,
    input  logic [N-1:0]     cnt,
    output logic [N-1:0]     exp_cnt,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    // Monitor states
    localparam logic [1:0] StIdle  = 2'd0;  // waiting for the first post-clear sample
    localparam logic [1:0] StTrack = 2'd1;  // locked, every step is checked
    localparam logic [1:0] StLost  = 2'd2;  // re-acquiring after an error

    localparam logic [N-1:0]     CntOne    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     CntZero   = '0;
    localparam logic [N-1:0]     CntMax    = '1;
    localparam logic [ERR_W-1:0] ErrOne    = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ErrMax    = '1;
    localparam logic [3:0]       RunOne    = 4'd1;
    localparam logic [3:0]       ResyncRun = 4'(RESYNC);

    // State registers
    logic [1:0]       state_q,   state_d;
    logic [N-1:0]     cnt_q,     cnt_d;
    logic             ena_q,     ena_d;
    logic [3:0]       run_q,     run_d;

    // Output registers
    logic [N-1:0]     exp_cnt_q, exp_cnt_d;
    logic             locked_q,  locked_d;
    logic             err_q,     err_d;
    logic             wrap_q,    wrap_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Helpers
    logic [N-1:0]     pred;
    logic             match;
    logic [3:0]       run_inc;
    logic [ERR_W-1:0] err_cnt_inc;

    always_comb begin
        // What the counter must show now, given what it showed and was told last edge.
        pred        = ena_q ? (cnt_q + CntOne) : cnt_q;
        match       = (cnt == pred);
        run_inc     = run_q + RunOne;
        err_cnt_inc = (err_cnt_q == ErrMax) ? err_cnt_q : (err_cnt_q + ErrOne);

        // The sample pipeline reloads on every edge, whatever the state; in LOST this is
        // what rebuilds the prediction from the counter's own latest value.
        cnt_d     = cnt;
        ena_d     = ena;
        exp_cnt_d = ena ? (cnt + CntOne) : cnt;

        state_d   = state_q;
        run_d     = run_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        wrap_d    = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            StIdle: begin
                // A counter cleared by the same clr_n must read 0 on the first free edge.
                if (cnt == CntZero) begin
                    state_d  = StTrack;
                    locked_d = 1'b1;
                end else begin
                    state_d   = StLost;
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_inc;
                    run_d     = 4'd0;
                end
            end

            StTrack: begin
                if (match) begin
                    wrap_d = ena_q && (cnt_q == CntMax) && (cnt == CntZero);
                end else begin
                    state_d   = StLost;
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_inc;
                    locked_d  = 1'b0;
                    run_d     = 4'd0;
                end
            end

            StLost: begin
                // Errors are not re-reported here; a mismatch only restarts the run.
                if (match) begin
                    if (run_inc == ResyncRun) begin
                        state_d  = StTrack;
                        locked_d = 1'b1;
                        run_d    = 4'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end else begin
                    run_d = 4'd0;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a fresh acquisition.
                state_d  = StIdle;
                locked_d = 1'b0;
                run_d    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ena_q     <= 1'b0;
            run_q     <= 4'd0;
            exp_cnt_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ena_q     <= ena_d;
            run_q     <= run_d;
            exp_cnt_q <= exp_cnt_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign exp_cnt = exp_cnt_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cnt_monitor.sv
// Self-checking bench for cnt_monitor (N=4, ERR_W=8, RESYNC=4).
// A table of {clr_n, ena, cnt} -> {exp_cnt, locked, err, wrap, err_cnt} vectors covers
// clear, counting, holding, glitches in TRACK and LOST, and clear mid-LOST. Two looped
// sequences cover wrap over 40 cycles and error-counter saturation over 300 glitches.

module tb_cnt_monitor;

    logic       clk;
    logic       clr_n;
    logic       ena;
    logic [3:0] cnt;
    logic [3:0] exp_cnt;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] err_cnt;

    int checks;
    int errors;

    typedef struct {
        logic       clr_n;
        logic       ena;
        logic [3:0] cnt;
        logic [3:0] exp_cnt;
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] err_cnt;
    } vec_t;

    vec_t vecs[$];

    cnt_monitor #(
        .N      (4),
        .ERR_W  (8),
        .RESYNC (4)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .ena     (ena),
        .cnt     (cnt),
        .exp_cnt (exp_cnt),
        .locked  (locked),
        .err     (err),
        .wrap    (wrap),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic e, input logic [3:0] v,
                                input logic [3:0] x, input logic l, input logic er,
                                input logic w, input logic [7:0] ec);
        vec_t r;
        r.clr_n   = c;
        r.ena     = e;
        r.cnt     = v;
        r.exp_cnt = x;
        r.locked  = l;
        r.err     = er;
        r.wrap    = w;
        r.err_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive inputs, let one rising edge pass, then settle before sampling.
    task automatic apply(input logic c, input logic e, input logic [3:0] v);
        clr_n = c;
        ena   = e;
        cnt   = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur;
        int exp_ec;
        checks = 0;
        errors = 0;
        clr_n  = 1'b0;
        ena    = 1'b0;
        cnt    = 4'd0;

        //               clr ena cnt    exp  lck err wrp ec
        // Clear held 5 cycles, garbage on cnt must be ignored.
        vecs.push_back(mk(0, 1, 4'd9,  4'd0,  0, 0, 0, 8'd0));
        vecs.push_back(mk(0, 1, 4'd0,  4'd0,  0, 0, 0, 8'd0));
        vecs.push_back(mk(0, 1, 4'd0,  4'd0,  0, 0, 0, 8'd0));
        vecs.push_back(mk(0, 1, 4'd0,  4'd0,  0, 0, 0, 8'd0));
        vecs.push_back(mk(0, 1, 4'd0,  4'd0,  0, 0, 0, 8'd0));
        // Release with a correctly cleared counter, count up to 6.
        vecs.push_back(mk(1, 1, 4'd0,  4'd1,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd1,  4'd2,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd2,  4'd3,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd3,  4'd4,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd4,  4'd5,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd5,  4'd6,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd6,  4'd7,  1, 0, 0, 8'd0));
        // Hold at 7 for 5 cycles, then resume.
        vecs.push_back(mk(1, 0, 4'd7,  4'd7,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 4'd7,  4'd7,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 4'd7,  4'd7,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 4'd7,  4'd7,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 4'd7,  4'd7,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd7,  4'd8,  1, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 4'd8,  4'd9,  1, 0, 0, 8'd0));
        // Jump 8 -> 12, then count correctly; relock on the 4th correct step.
        vecs.push_back(mk(1, 1, 4'd12, 4'd13, 0, 1, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd13, 4'd14, 0, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd14, 4'd15, 0, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd15, 4'd0,  0, 0, 0, 8'd1));
        // 15 -> 0 while in LOST: relocks, but no wrap pulse.
        vecs.push_back(mk(1, 1, 4'd0,  4'd1,  1, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd1,  4'd2,  1, 0, 0, 8'd1));
        // Glitch, two good steps, glitch in LOST (no err, run restarts).
        vecs.push_back(mk(1, 1, 4'd5,  4'd6,  0, 1, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd6,  4'd7,  0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd7,  4'd8,  0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd3,  4'd4,  0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd4,  4'd5,  0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd5,  4'd6,  0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd6,  4'd7,  0, 0, 0, 8'd2));
        vecs.push_back(mk(1, 1, 4'd7,  4'd8,  1, 0, 0, 8'd2));
        // Glitch into LOST, then clear mid-LOST.
        vecs.push_back(mk(1, 1, 4'd0,  4'd1,  0, 1, 0, 8'd3));
        vecs.push_back(mk(0, 1, 4'd1,  4'd0,  0, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0));
        // Release with cnt=3: first sample must be 0, so error from IDLE.
        vecs.push_back(mk(1, 1, 4'd3,  4'd4,  0, 1, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd4,  4'd5,  0, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd5,  4'd6,  0, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd6,  4'd7,  0, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd7,  4'd8,  1, 0, 0, 8'd1));
        // ena dropped at 8 but the counter still advances at the next edge.
        vecs.push_back(mk(1, 0, 4'd8,  4'd8,  1, 0, 0, 8'd1));
        vecs.push_back(mk(1, 1, 4'd9,  4'd10, 0, 1, 0, 8'd2));
        vecs.push_back(mk(0, 0, 4'd0,  4'd0,  0, 0, 0, 8'd0));

        foreach (vecs[i]) begin
            apply(vecs[i].clr_n, vecs[i].ena, vecs[i].cnt);
            check($sformatf("vec%0d exp_cnt", i), 32'(exp_cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d locked", i),  32'(locked),  32'(vecs[i].locked));
            check($sformatf("vec%0d err", i),     32'(err),     32'(vecs[i].err));
            check($sformatf("vec%0d wrap", i),    32'(wrap),    32'(vecs[i].wrap));
            check($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].err_cnt));
        end

        // 40 cycles of free counting from a clean clear: wrap after each 15 -> 0.
        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 1'b1, 4'(i % 16));
            check($sformatf("run%0d wrap", i),    32'(wrap),    32'((i != 0 && i % 16 == 0) ? 1 : 0));
            check($sformatf("run%0d err", i),     32'(err),     32'd0);
            check($sformatf("run%0d locked", i),  32'(locked),  32'd1);
            check($sformatf("run%0d exp_cnt", i), 32'(exp_cnt), 32'((i + 1) % 16));
        end

        // 300 isolated glitches, each followed by 5 correct steps.
        cur = 7;
        for (int g = 0; g < 300; g++) begin
            cur    = (cur + 6) % 16;
            exp_ec = (g + 1 > 255) ? 255 : g + 1;
            apply(1'b1, 1'b1, 4'(cur));
            check($sformatf("glitch%0d err", g),     32'(err),     32'd1);
            check($sformatf("glitch%0d locked", g),  32'(locked),  32'd0);
            check($sformatf("glitch%0d err_cnt", g), 32'(err_cnt), 32'(exp_ec));
            for (int s = 1; s <= 5; s++) begin
                cur = (cur + 1) % 16;
                apply(1'b1, 1'b1, 4'(cur));
                check($sformatf("glitch%0d step%0d err", g, s), 32'(err), 32'd0);
                if (s == 3) check($sformatf("glitch%0d early lock", g), 32'(locked), 32'd0);
                if (s == 4) check($sformatf("glitch%0d relock", g), 32'(locked), 32'd1);
            end
        end

        // Final clear returns the saturated counter and everything else to reset values.
        apply(1'b0, 1'b0, 4'd0);
        check("final exp_cnt", 32'(exp_cnt), 32'd0);
        check("final locked",  32'(locked),  32'd0);
        check("final err",     32'(err),     32'd0);
        check("final wrap",    32'(wrap),    32'd0);
        check("final err_cnt", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
